layer_sequencer: RTL and testbench

//  Sequences one fully-connected layer pass: drives en/clear of the 4-bit element index counter, walks

---
 rtl/layer_sequencer_pkg.sv | 33 +++
 rtl/layer_sequencer_if.sv | 40 ++++
 rtl/layer_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// layer_sequencer_pkg
// Shared definitions for the fully-connected layer sequencer: state encoding,
// vector length, vector-index width and a last-vector helper.
// No ports (package).
// ----------------------------------------------------------------------------
package layer_sequencer_pkg;

  // Elements per vector. The external element index counter flags the end of
  // a vector with bit 3 of its index, so this value cannot change on its own.
  localparam int VEC_LEN = 8;

  // Width of vector_index / num_vectors.
  localparam int VIDX_W = 4;

  localparam logic [VIDX_W-1:0] VIDX_ZERO = {VIDX_W{1'b0}};
  localparam logic [VIDX_W-1:0] VIDX_ONE  = {{(VIDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CLEAR = 3'd1,
    SEQ_RUN   = 3'd2,
    SEQ_BIAS  = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  // True when idx is the final vector of a pass of cnt vectors.
  function automatic logic is_last_vector(input logic [VIDX_W-1:0] idx,
                                          input logic [VIDX_W-1:0] cnt);
    return (idx == (cnt - VIDX_ONE));
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// ----------------------------------------------------------------------------
// layer_sequencer_if
// Bundles the control, data handshake and datapath-control signals between
// the layer control FSM / MAC datapath (master side) and the sequencer
// (slave side).
//   master drives : start, abort, num_vectors, data_valid, new_vector
//   slave drives  : data_ready, elem_en, elem_clear, acc_en, acc_clear,
//                   bias_en, result_valid, vector_index, busy, done
// ----------------------------------------------------------------------------
interface layer_sequencer_if;

  logic                                   start;
  logic                                   abort;
  logic [layer_sequencer_pkg::VIDX_W-1:0] num_vectors;
  logic                                   data_valid;
  logic                                   new_vector;
  logic                                   data_ready;
  logic                                   elem_en;
  logic                                   elem_clear;
  logic                                   acc_en;
  logic                                   acc_clear;
  logic                                   bias_en;
  logic                                   result_valid;
  logic [layer_sequencer_pkg::VIDX_W-1:0] vector_index;
  logic                                   busy;
  logic                                   done;

  modport master (
    output start, abort, num_vectors, data_valid, new_vector,
    input  data_ready, elem_en, elem_clear, acc_en, acc_clear, bias_en,
           result_valid, vector_index, busy, done
  );

  modport slave (
    input  start, abort, num_vectors, data_valid, new_vector,
    output data_ready, elem_en, elem_clear, acc_en, acc_clear, bias_en,
           result_valid, vector_index, busy, done
  );

endinterface

// File: rtl/layer_sequencer.sv
// ----------------------------------------------------------------------------
// layer_sequencer
// Sequences one fully-connected layer pass: clears and enables the external
// 4-bit element index counter, walks vector_index over num_vectors vectors,
// gates the element handshake and the MAC accumulator, and pulses
// result_valid per vector and done at the end of the pass.
//
// Ports
//   i_clock    : rising-edge clock
//   i_reset_n  : asynchronous active-low reset
//   io_seq     : layer_sequencer_if.slave (see interface for signal list)
//
// Build option
//   LAYER_SEQ_BIAS_STAGE_EN : adds the one-cycle BIAS state after each
//   vector; result_valid/acc_clear then follow one cycle after bias_en.
//   Undefined: no BIAS state, bias_en is constant 0.
// ----------------------------------------------------------------------------
module layer_sequencer
  import layer_sequencer_pkg::*;
(
  input  logic            i_clock,
  input  logic            i_reset_n,
  layer_sequencer_if.slave io_seq
);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [VIDX_W-1:0] r_count;
  logic [VIDX_W-1:0] w_count_nxt;
  logic [VIDX_W-1:0] r_vidx;
  logic [VIDX_W-1:0] w_vidx_nxt;
  logic              w_last;
  logic              w_take;
  logic              w_data_ready;
  logic              w_elem_clear;
  logic              w_acc_clear;
  logic              w_bias_en;
  logic              w_result_valid;
  logic              w_done;
`ifdef LAYER_SEQ_BIAS_STAGE_EN
  // Marks the cycle after BIAS, where the finished vector is reported.
  logic              r_post_bias;
  logic              w_post_bias_nxt;
`endif

  assign w_last = is_last_vector(r_vidx, r_count);

  // State, captured vector count and vector index registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= SEQ_IDLE;
      r_count <= VIDX_ZERO;
      r_vidx  <= VIDX_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_vidx  <= w_vidx_nxt;
    end
  end

`ifdef LAYER_SEQ_BIAS_STAGE_EN
  // Post-bias reporting flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_post_bias <= 1'b0;
    end else begin
      r_post_bias <= w_post_bias_nxt;
    end
  end
`endif

  // Next-state and output decode; abort overrides every transition.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_vidx_nxt     = r_vidx;
    w_take         = 1'b0;
    w_elem_clear   = 1'b0;
    w_acc_clear    = 1'b0;
    w_bias_en      = 1'b0;
    w_result_valid = 1'b0;
    w_done         = 1'b0;
`ifdef LAYER_SEQ_BIAS_STAGE_EN
    w_post_bias_nxt = 1'b0;
`endif

    case (r_state)
      SEQ_IDLE: begin
        if (io_seq.start) begin
          w_count_nxt = io_seq.num_vectors;
          w_vidx_nxt  = VIDX_ZERO;
          w_state_nxt = SEQ_CLEAR;
        end else begin
          w_state_nxt = SEQ_IDLE;
        end
      end

      SEQ_CLEAR: begin
        w_elem_clear = 1'b1;
        w_acc_clear  = 1'b1;
        if (r_count == VIDX_ZERO) begin
          w_state_nxt = SEQ_DONE;
        end else begin
          w_state_nxt = SEQ_RUN;
        end
      end

      SEQ_RUN: begin
        w_take = 1'b1;
`ifdef LAYER_SEQ_BIAS_STAGE_EN
        if (r_post_bias) begin
          // Report the vector finished by BIAS. The counter is already back
          // at 0, so the next vector's first element may be taken here; on
          // the last vector the pass ends and nothing more is accepted.
          w_result_valid = 1'b1;
          w_acc_clear    = 1'b1;
          if (w_last) begin
            w_take      = 1'b0;
            w_state_nxt = SEQ_DONE;
          end else begin
            w_vidx_nxt  = r_vidx + VIDX_ONE;
          end
        end else if (io_seq.new_vector) begin
          w_state_nxt = SEQ_BIAS;
        end else begin
          w_state_nxt = SEQ_RUN;
        end
`else
        if (io_seq.new_vector) begin
          w_result_valid = 1'b1;
          w_acc_clear    = 1'b1;
          if (w_last) begin
            w_state_nxt = SEQ_DONE;
          end else begin
            w_vidx_nxt  = r_vidx + VIDX_ONE;
          end
        end else begin
          w_state_nxt = SEQ_RUN;
        end
`endif
      end

`ifdef LAYER_SEQ_BIAS_STAGE_EN
      SEQ_BIAS: begin
        w_bias_en       = 1'b1;
        w_post_bias_nxt = 1'b1;
        w_state_nxt     = SEQ_RUN;
      end
`endif

      SEQ_DONE: begin
        w_done       = 1'b1;
        w_elem_clear = 1'b1;
        w_state_nxt  = SEQ_IDLE;
      end

      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase

    if (io_seq.abort && (r_state != SEQ_IDLE)) begin
      w_state_nxt    = SEQ_IDLE;
      w_count_nxt    = r_count;
      w_vidx_nxt     = r_vidx;
      w_take         = 1'b0;
      w_elem_clear   = 1'b1;
      w_acc_clear    = 1'b1;
      w_bias_en      = 1'b0;
      w_result_valid = 1'b0;
      w_done         = 1'b0;
`ifdef LAYER_SEQ_BIAS_STAGE_EN
      w_post_bias_nxt = 1'b0;
`endif
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // No element is taken on the counter's wrap cycle.
  assign w_data_ready        = w_take && !io_seq.new_vector;

  assign io_seq.data_ready   = w_data_ready;
  assign io_seq.elem_en      = w_data_ready && io_seq.data_valid;
  assign io_seq.acc_en       = w_data_ready && io_seq.data_valid;
  assign io_seq.elem_clear   = w_elem_clear;
  assign io_seq.acc_clear    = w_acc_clear;
  assign io_seq.bias_en      = w_bias_en;
  assign io_seq.result_valid = w_result_valid;
  assign io_seq.done         = w_done;
  assign io_seq.vector_index = r_vidx;
  assign io_seq.busy         = (r_state != SEQ_IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_layer_sequencer
// Bench for layer_sequencer together with a behavioural element index
// counter. Expected values come from the pass rules: 8 accepts per vector,
// result one cycle after the 8th accept (three with the bias stage), done one
// cycle after the last result, fixed full-rate result cycles.
// ----------------------------------------------------------------------------
module tb_layer_sequencer;

`ifdef LAYER_SEQ_BIAS_STAGE_EN
  localparam int LAT = 3, PERIOD = 10, FIRST = 12, BIAS = 1;
`else
  localparam int LAT = 1, PERIOD = 9, FIRST = 10, BIAS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] r_elem;

  layer_sequencer_if sif();

  layer_sequencer dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_seq    (sif)
  );

  always #5 clk = ~clk;

  // Element index counter: sync clear, self-wrap at 8, count on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_elem <= 4'd0;
    else if (sif.elem_clear) r_elem <= 4'd0;
    else if (r_elem[3])      r_elem <= 4'd0;
    else if (sif.elem_en)    r_elem <= r_elem + 4'd1;
  end
  assign sif.new_vector = r_elem[3];

  int checks = 0;
  int errors = 0;

  // Observations of one pass
  int obs_acc, obs_ready, obs_done, obs_done_cyc, obs_bias, obs_bias_viol;
  int obs_nv_viol, obs_hs_viol, obs_end_cyc, obs_timeout;
  int obs_abort_seen, obs_abort_clr, obs_abort_rv;
  logic [3:0] obs_end_vidx;
  int q_cyc[$], q_vidx[$], q_acc[$], q_lat[$];

  function automatic logic pick_valid(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ~c[0];
      default: return ($urandom_range(0, 9) < 7);
    endcase
  endfunction

  // Drives one pass from a start pulse and records what the DUT does.
  task automatic run_pass(input int n, input int mode, input int abort_at);
    logic prev_nv;
    int last_acc;
    bit fired;
    obs_acc = 0; obs_ready = 0; obs_done = 0; obs_done_cyc = -1;
    obs_bias = 0; obs_bias_viol = 0; obs_nv_viol = 0; obs_hs_viol = 0;
    obs_end_cyc = -1; obs_timeout = 1; obs_end_vidx = 4'd0;
    obs_abort_seen = 0; obs_abort_clr = 0; obs_abort_rv = 0;
    q_cyc.delete(); q_vidx.delete(); q_acc.delete(); q_lat.delete();
    prev_nv = 1'b0; last_acc = -100; fired = 1'b0;
    @(posedge clk); #1;
    sif.start = 1'b1; sif.num_vectors = n[3:0];
    sif.data_valid = pick_valid(mode, 0); sif.abort = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c > 0 && !sif.busy) begin
        obs_timeout = 0; obs_end_cyc = c; obs_end_vidx = sif.vector_index;
        sif.start = 1'b0; sif.abort = 1'b0; sif.data_valid = 1'b0;
        break;
      end
      if (sif.data_ready) obs_ready++;
      if (sif.elem_en && sif.new_vector) obs_nv_viol++;
      if ((sif.elem_en !== (sif.data_valid && sif.data_ready)) ||
          (sif.acc_en !== sif.elem_en)) obs_hs_viol++;
      if (sif.result_valid) begin
        q_cyc.push_back(c); q_vidx.push_back(int'(sif.vector_index));
        q_acc.push_back(obs_acc); q_lat.push_back(c - last_acc);
      end
      if (sif.data_valid && sif.data_ready) begin obs_acc++; last_acc = c; end
      if (sif.bias_en) begin obs_bias++; if (!prev_nv) obs_bias_viol++; end
      if (sif.done) begin obs_done++; obs_done_cyc = c; end
      if (sif.abort) begin
        obs_abort_seen++;
        obs_abort_clr = int'(sif.elem_clear && sif.acc_clear);
        obs_abort_rv  = int'(sif.result_valid || sif.done);
      end
      prev_nv = sif.new_vector;
      @(posedge clk); #1;
      sif.start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      sif.num_vectors = (mode == 2) ? 4'($urandom_range(0, 15)) : n[3:0];
      sif.data_valid = pick_valid(mode, c + 1);
      sif.abort = (abort_at >= 0 && obs_acc == abort_at && !fired);
      if (sif.abort) fired = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    sif.start = 1'b0; sif.abort = 1'b0; sif.data_valid = 1'b0; sif.num_vectors = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {sif.data_ready, sif.elem_en, sif.elem_clear, sif.acc_en, sif.acc_clear,
            sif.bias_en, sif.result_valid, sif.busy, sif.done, sif.vector_index};
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst_n = 1'b1;
    @(posedge clk); #1; sif.abort = 1'b1;
    @(posedge clk); #1; sif.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL abort_in_idle busy got %b want 0", sif.busy); end
  endtask

  task automatic test_full_rate();
    run_pass(3, 0, -1);
    checks++;
    if (obs_timeout != 0) begin errors++; $display("FAIL full_timeout got %0d want 0", obs_timeout); end
    checks++;
    if (obs_acc != 24) begin errors++; $display("FAIL full_accepts got %0d want 24", obs_acc); end
    checks++;
    if (q_cyc.size() != 3) begin errors++; $display("FAIL full_pulses got %0d want 3", q_cyc.size()); end
    for (int k = 0; k < q_cyc.size(); k++) begin
      checks++;
      if (q_cyc[k] != FIRST + PERIOD * k || q_vidx[k] != k) begin
        errors++;
        $display("FAIL full_pulse%0d got cyc %0d idx %0d want cyc %0d idx %0d",
                 k, q_cyc[k], q_vidx[k], FIRST + PERIOD * k, k);
      end
    end
    checks++;
    if (obs_done != 1 || obs_done_cyc != FIRST + PERIOD * 2 + 1) begin
      errors++;
      $display("FAIL full_done got cnt %0d cyc %0d want 1 at %0d", obs_done, obs_done_cyc, FIRST + PERIOD * 2 + 1);
    end
    checks++;
    if (obs_end_cyc != obs_done_cyc + 1 || obs_end_vidx !== 4'd2) begin
      errors++;
      $display("FAIL full_idle got end %0d idx %0d want %0d idx 2", obs_end_cyc, obs_end_vidx, obs_done_cyc + 1);
    end
    checks++;
    if (obs_bias != 3 * BIAS || obs_bias_viol != 0) begin
      errors++; $display("FAIL full_bias got %0d viol %0d want %0d viol 0", obs_bias, obs_bias_viol, 3 * BIAS);
    end
  endtask

  task automatic test_zero_vectors();
    run_pass(0, 0, -1);
    checks++;
    if (obs_ready != 0 || q_cyc.size() != 0) begin
      errors++; $display("FAIL zero_activity got ready %0d pulses %0d want 0 0", obs_ready, q_cyc.size());
    end
    checks++;
    if (obs_done != 1 || obs_done_cyc != 2 || obs_end_vidx !== 4'd0) begin
      errors++;
      $display("FAIL zero_done got cnt %0d cyc %0d idx %0d want 1 2 0", obs_done, obs_done_cyc, obs_end_vidx);
    end
  endtask

  task automatic test_stall_patterns();
    for (int p = 0; p < 5; p++) begin
      int n, mode;
      mode = (p == 0) ? 1 : 2;
      n = (p == 0) ? 3 : int'($urandom_range(1, 6));
      run_pass(n, mode, -1);
      checks++;
      if (obs_timeout != 0 || obs_acc != 8 * n || q_cyc.size() != n) begin
        errors++;
        $display("FAIL stall%0d_totals got to %0d acc %0d pulses %0d want 0 %0d %0d",
                 p, obs_timeout, obs_acc, q_cyc.size(), 8 * n, n);
      end
      for (int k = 0; k < q_cyc.size(); k++) begin
        checks++;
        if (q_acc[k] != 8 * (k + 1) || q_lat[k] != LAT || q_vidx[k] != k) begin
          errors++;
          $display("FAIL stall%0d_vec%0d got acc %0d lat %0d idx %0d want %0d %0d %0d",
                   p, k, q_acc[k], q_lat[k], q_vidx[k], 8 * (k + 1), LAT, k);
        end
      end
      checks++;
      if (obs_nv_viol != 0 || obs_hs_viol != 0) begin
        errors++; $display("FAIL stall%0d_enables got nv %0d hs %0d want 0 0", p, obs_nv_viol, obs_hs_viol);
      end
      checks++;
      if (q_cyc.size() > 0 && (obs_done != 1 || obs_done_cyc != q_cyc[q_cyc.size() - 1] + 1)) begin
        errors++; $display("FAIL stall%0d_done got cnt %0d cyc %0d", p, obs_done, obs_done_cyc);
      end
      checks++;
      if (obs_bias != n * BIAS || obs_bias_viol != 0) begin
        errors++; $display("FAIL stall%0d_bias got %0d viol %0d want %0d", p, obs_bias, obs_bias_viol, n * BIAS);
      end
    end
  endtask

  task automatic test_abort();
    run_pass(3, 0, 12);
    checks++;
    if (obs_abort_seen != 1 || obs_abort_clr != 1 || obs_abort_rv != 0) begin
      errors++;
      $display("FAIL abort_cycle got seen %0d clr %0d rv %0d want 1 1 0", obs_abort_seen, obs_abort_clr, obs_abort_rv);
    end
    checks++;
    if (obs_timeout != 0 || obs_done != 0 || q_cyc.size() != 1 || obs_acc != 12) begin
      errors++;
      $display("FAIL abort_pass got to %0d done %0d pulses %0d acc %0d want 0 0 1 12",
               obs_timeout, obs_done, q_cyc.size(), obs_acc);
    end
    run_pass(2, 1, -1);
    checks++;
    if (obs_acc != 16 || q_cyc.size() != 2 || obs_done != 1 || obs_end_vidx !== 4'd1) begin
      errors++;
      $display("FAIL abort_restart got acc %0d pulses %0d done %0d idx %0d want 16 2 1 1",
               obs_acc, q_cyc.size(), obs_done, obs_end_vidx);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [12:0] outs;
    int k;
    k = 2 + 2 * PERIOD + 5;
    @(posedge clk); #1;
    sif.start = 1'b1; sif.num_vectors = 4'd4; sif.data_valid = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (k - 1) @(posedge clk);
    #2;
    checks++;
    if (r_elem !== 4'd5 || sif.vector_index !== 4'd2 || sif.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_position got elem %0d idx %0d rdy %b want 5 2 1", r_elem, sif.vector_index, sif.data_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    outs = {sif.data_ready, sif.elem_en, sif.elem_clear, sif.acc_en, sif.acc_clear,
            sif.bias_en, sif.result_valid, sif.busy, sif.done, sif.vector_index};
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL midrun_reset got %h want 0", outs); end
    #4 rst_n = 1'b1;
    sif.data_valid = 1'b0;
    run_pass(2, 0, -1);
    checks++;
    if (q_cyc.size() != 2 || obs_acc != 16 || obs_done != 1) begin
      errors++; $display("FAIL midrun_restart got pulses %0d acc %0d done %0d want 2 16 1", q_cyc.size(), obs_acc, obs_done);
    end
    for (int j = 0; j < q_cyc.size(); j++) begin
      checks++;
      if (q_cyc[j] != FIRST + PERIOD * j || q_vidx[j] != j) begin
        errors++; $display("FAIL midrun_pulse%0d got cyc %0d idx %0d", j, q_cyc[j], q_vidx[j]);
      end
    end
  endtask

  task automatic test_max_length();
    run_pass(15, 0, -1);
    checks++;
    if (q_cyc.size() != 15 || obs_acc != 120 || obs_end_vidx !== 4'd14) begin
      errors++;
      $display("FAIL max_pass got pulses %0d acc %0d idx %0d want 15 120 14", q_cyc.size(), obs_acc, obs_end_vidx);
    end
    checks++;
    if (obs_done != 1 || obs_done_cyc != FIRST + PERIOD * 14 + 1) begin
      errors++; $display("FAIL max_done got cnt %0d cyc %0d want 1 %0d", obs_done, obs_done_cyc, FIRST + PERIOD * 14 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_zero_vectors();
    test_stall_patterns();
    test_abort();
    test_reset_mid_run();
    test_max_length();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
